exec_trace_buffer: RTL and testbench

Synthesizable event-capture block that sits beside the `riscv` core and records register-file writes and data-memory accesses into a parametrised FIFO with cycle timestamps. Each entry is drained over a valid/ready stream by a debug UART, a JTAG reader or a bench scoreboard. Per-event-class enable masks and a selectable full policy (stall or overwrite-oldest) are provided, so long programs run in silicon or simulation without a `$display` monitor.

---
 rtl/exec_trace_buffer.sv | 131 +++++++++++++
 tb/tb_exec_trace_buffer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/exec_trace_buffer.sv
// rtl/exec_trace_buffer.sv - timestamped capture FIFO for core register-file writes and data-memory accesses
module exec_trace_buffer #(
  parameter  int DEPTH  = 16,
  parameter  int TS_W   = 16,
  parameter  int ADDR_W = 9,
  parameter  int DATA_W = 32,
  parameter  int REG_W  = 5,
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write_sig,
  input  logic [REG_W-1:0]  reg_num,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              wr,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] rd_data,
  input  logic [2:0]        en_mask,
  input  logic              overwrite_mode,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_kind,
  output logic [TS_W-1:0]   out_ts,
  output logic [REG_W-1:0]  out_reg_num,
  output logic [DATA_W-1:0] out_reg_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_mem_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic [15:0]       drop_count
);

  logic [3:0]        kind_mem [DEPTH];
  logic [TS_W-1:0]   ts_mem   [DEPTH];
  logic [REG_W-1:0]  rnum_mem [DEPTH];
  logic [DATA_W-1:0] rdat_mem [DEPTH];
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] mdat_mem [DEPTH];

  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count_q;
  logic [15:0]      drop_q;
  logic [TS_W-1:0]  ts_q;

  logic              ev_reg, ev_mwr, ev_mrd, ev_conf, ev_mem;
  logic [3:0]        new_kind;
  logic [REG_W-1:0]  new_rnum;
  logic [DATA_W-1:0] new_rdat, new_mdat;
  logic [ADDR_W-1:0] new_addr;
  logic              push, pop, is_full, blocked, do_write, do_evict, cnt_inc, cnt_dec;

  always_comb begin
    ev_reg   = reg_write_sig & en_mask[0];
    ev_mwr   = wr & ~rd & en_mask[1];
    ev_mrd   = rd & ~wr & en_mask[2];
    ev_conf  = wr & rd & (en_mask[1] | en_mask[2]);
    ev_mem   = ev_mwr | ev_mrd | ev_conf;
    new_kind = {ev_conf, ev_mrd, ev_mwr, ev_reg};
    new_rnum = ev_reg ? reg_num : '0;
    new_rdat = ev_reg ? reg_data : '0;
    new_addr = ev_mem ? addr : '0;
    new_mdat = '0;
    if (ev_mwr || ev_conf) new_mdat = wr_data;
    else if (ev_mrd)       new_mdat = rd_data;
  end

  // A full FIFO with no pop either drops the newcomer or evicts the head to make room.
  always_comb begin
    is_full  = (count_q == CNT_W'(DEPTH));
    push     = (|new_kind) & ~clear;
    pop      = (count_q != '0) & out_ready & ~clear;
    blocked  = push & ~pop & is_full;
    do_write = push & (~blocked | overwrite_mode);
    do_evict = blocked & overwrite_mode;
    cnt_inc  = do_write & ~pop & ~do_evict;
    cnt_dec  = pop & ~do_write;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      drop_q  <= '0;
      ts_q    <= '0;
    end else if (clear) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      drop_q  <= '0;
      ts_q    <= '0;
    end else begin
      ts_q <= ts_q + 1'b1;
      if (do_write)            wr_ptr <= wr_ptr + 1'b1;
      if (pop || do_evict)     rd_ptr <= rd_ptr + 1'b1;
      if (cnt_inc)             count_q <= count_q + 1'b1;
      else if (cnt_dec)        count_q <= count_q - 1'b1;
      if (blocked && drop_q != 16'hFFFF) drop_q <= drop_q + 1'b1;
    end
  end

  // Payload storage needs no reset: nothing is presented unless count is non-zero.
  always_ff @(posedge clk) begin
    if (do_write) begin
      kind_mem[wr_ptr] <= new_kind;
      ts_mem[wr_ptr]   <= ts_q;
      rnum_mem[wr_ptr] <= new_rnum;
      rdat_mem[wr_ptr] <= new_rdat;
      addr_mem[wr_ptr] <= new_addr;
      mdat_mem[wr_ptr] <= new_mdat;
    end
  end

  assign out_valid    = (count_q != '0);
  assign empty        = ~out_valid;
  assign full         = is_full;
  assign count        = count_q;
  assign drop_count   = drop_q;
  assign out_kind     = out_valid ? kind_mem[rd_ptr] : '0;
  assign out_ts       = out_valid ? ts_mem[rd_ptr]   : '0;
  assign out_reg_num  = out_valid ? rnum_mem[rd_ptr] : '0;
  assign out_reg_data = out_valid ? rdat_mem[rd_ptr] : '0;
  assign out_addr     = out_valid ? addr_mem[rd_ptr] : '0;
  assign out_mem_data = out_valid ? mdat_mem[rd_ptr] : '0;

endmodule

// File: tb/tb_exec_trace_buffer.sv
// tb/tb_exec_trace_buffer.sv - directed and randomized checks of exec_trace_buffer against a queue model
module tb_exec_trace_buffer;
  localparam int DEPTH = 4;
  localparam int TS_W = 4;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int REG_W = 5;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              tb_clk = 1'b0;
  logic              reset;
  logic              reg_write_sig;
  logic [REG_W-1:0]  reg_num;
  logic [DATA_W-1:0] reg_data;
  logic              wr, rd;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data, rd_data;
  logic [2:0]        en_mask;
  logic              overwrite_mode, clear, out_ready;
  logic              out_valid, full, empty;
  logic [3:0]        out_kind;
  logic [TS_W-1:0]   out_ts;
  logic [REG_W-1:0]  out_reg_num;
  logic [DATA_W-1:0] out_reg_data;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_mem_data;
  logic [CNT_W-1:0]  count;
  logic [15:0]       drop_count;

  exec_trace_buffer #(.DEPTH(DEPTH), .TS_W(TS_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk(tb_clk), .reset(reset), .reg_write_sig(reg_write_sig), .reg_num(reg_num), .reg_data(reg_data),
    .wr(wr), .rd(rd), .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .en_mask(en_mask),
    .overwrite_mode(overwrite_mode), .clear(clear), .out_valid(out_valid), .out_ready(out_ready),
    .out_kind(out_kind), .out_ts(out_ts), .out_reg_num(out_reg_num), .out_reg_data(out_reg_data),
    .out_addr(out_addr), .out_mem_data(out_mem_data), .count(count), .full(full), .empty(empty),
    .drop_count(drop_count)
  );

  always #5 tb_clk = ~tb_clk;

  typedef struct {
    logic [3:0]        kind;
    logic [TS_W-1:0]   ts;
    logic [REG_W-1:0]  rn;
    logic [DATA_W-1:0] rdat;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] mdat;
  } ent_t;

  ent_t q[$];
  int   m_drop = 0;
  int   m_ts = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t mk_entry();
    ent_t e;
    logic r, w, rr, c;
    r  = reg_write_sig & en_mask[0];
    w  = wr & ~rd & en_mask[1];
    rr = rd & ~wr & en_mask[2];
    c  = wr & rd & (en_mask[1] | en_mask[2]);
    e.kind = {c, rr, w, r};
    e.ts   = TS_W'(m_ts);
    e.rn   = r ? reg_num : '0;
    e.rdat = r ? reg_data : '0;
    e.addr = (w | rr | c) ? addr : '0;
    e.mdat = (w | c) ? wr_data : (rr ? rd_data : '0);
    return e;
  endfunction

  task automatic model_reset();
    q.delete();
    m_drop = 0;
    m_ts = 0;
  endtask

  task automatic model_step();
    ent_t e;
    if (clear) begin
      model_reset();
    end else begin
      e = mk_entry();
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (e.kind != 4'b0000) begin
        if (q.size() < DEPTH) q.push_back(e);
        else begin
          if (overwrite_mode) begin
            void'(q.pop_front());
            q.push_back(e);
          end
          if (m_drop < 65535) m_drop++;
        end
      end
      m_ts = (m_ts + 1) % (1 << TS_W);
    end
  endtask

  task automatic check_all();
    ent_t h;
    h = '{default: '0};
    if (q.size() > 0) h = q[0];
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("count", 64'(count), 64'(q.size()));
    chk("full", 64'(full), 64'(q.size() == DEPTH));
    chk("empty", 64'(empty), 64'(q.size() == 0));
    chk("drop_count", 64'(drop_count), 64'(m_drop));
    chk("out_kind", 64'(out_kind), 64'(h.kind));
    chk("out_ts", 64'(out_ts), 64'(h.ts));
    chk("out_reg_num", 64'(out_reg_num), 64'(h.rn));
    chk("out_reg_data", 64'(out_reg_data), 64'(h.rdat));
    chk("out_addr", 64'(out_addr), 64'(h.addr));
    chk("out_mem_data", 64'(out_mem_data), 64'(h.mdat));
  endtask

  task automatic tick();
    model_step();
    @(posedge tb_clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    reg_write_sig = 0; wr = 0; rd = 0; clear = 0; out_ready = 0;
  endtask

  task automatic reg_ev(input int n);
    idle();
    reg_write_sig = 1; reg_num = REG_W'(n); reg_data = DATA_W'(n * 11);
  endtask

  initial begin
    reset = 0; idle(); en_mask = 3'b111; overwrite_mode = 0;
    reg_num = '0; reg_data = '0; addr = '0; wr_data = '0; rd_data = '0;
    model_reset();
    @(posedge tb_clk); @(posedge tb_clk); #1;
    check_all();
    reset = 1;

    // ts 0..2 idle, capture at ts 3
    repeat (3) tick();
    reg_write_sig = 1; reg_num = 5; reg_data = 32'd42;
    tick();
    chk("first_kind", 64'(out_kind), 64'h1);
    chk("first_ts", 64'(out_ts), 64'd3);
    chk("first_reg", 64'(out_reg_data), 64'd42);
    chk("first_count", 64'(count), 64'd1);
    idle(); out_ready = 1; tick();

    idle(); reg_write_sig = 1; reg_num = 1; reg_data = 7; wr = 1; addr = 9'd16; wr_data = 99;
    tick();
    chk("dual_kind", 64'(out_kind), 64'h3);
    chk("dual_addr", 64'(out_addr), 64'd16);
    chk("dual_mdat", 64'(out_mem_data), 64'd99);
    chk("dual_reg", 64'(out_reg_data), 64'd7);
    idle(); out_ready = 1; tick();

    idle(); wr = 1; rd = 1; addr = 9'd8; wr_data = 32'h55; rd_data = 32'h66;
    tick();
    chk("conf_kind", 64'(out_kind), 64'h8);
    chk("conf_mdat", 64'(out_mem_data), 64'h55);
    idle(); out_ready = 1; tick();
    en_mask = 3'b001; idle(); wr = 1; rd = 1;
    tick();
    chk("conf_masked_count", 64'(count), 64'd0);
    en_mask = 3'b111;

    overwrite_mode = 0;
    for (int i = 1; i <= 6; i++) begin reg_ev(i); tick(); end
    chk("drop_full", 64'(full), 64'd1);
    chk("drop_cnt", 64'(drop_count), 64'd2);
    chk("drop_head", 64'(out_reg_num), 64'd1);
    idle(); clear = 1; tick();

    overwrite_mode = 1;
    for (int i = 1; i <= 6; i++) begin reg_ev(i); tick(); end
    chk("ovw_head", 64'(out_reg_num), 64'd3);
    chk("ovw_cnt", 64'(drop_count), 64'd2);
    reg_ev(7); out_ready = 1; tick();
    chk("pushpop_count", 64'(count), 64'd4);
    chk("pushpop_head", 64'(out_reg_num), 64'd4);
    reg_ev(8); clear = 1; tick();
    chk("clear_count", 64'(count), 64'd0);
    chk("clear_drop", 64'(drop_count), 64'd0);
    idle(); tick();
    reg_ev(9); tick();
    chk("clear_ts", 64'(out_ts), 64'd1);

    idle(); clear = 1; tick();
    idle(); repeat (15) tick();
    reg_ev(10); tick();
    chk("wrap_ts15", 64'(out_ts), 64'd15);
    idle(); tick();
    reg_ev(11); out_ready = 1; tick();
    chk("wrap_ts1", 64'(out_ts), 64'd1);

    // asynchronous reset between clock edges
    idle();
    #2 reset = 0;
    model_reset();
    #1;
    chk("async_valid", 64'(out_valid), 64'd0);
    check_all();
    @(posedge tb_clk); #1;
    reset = 1;

    for (int i = 0; i < 400; i++) begin
      reg_write_sig  = 1'($urandom);
      wr             = 1'($urandom);
      rd             = 1'($urandom);
      reg_num        = REG_W'($urandom);
      reg_data       = $urandom;
      addr           = ADDR_W'($urandom);
      wr_data        = $urandom;
      rd_data        = $urandom;
      en_mask        = 3'($urandom);
      overwrite_mode = 1'($urandom);
      out_ready      = ($urandom_range(0, 3) == 0);
      clear          = ($urandom_range(0, 31) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
